// File: rtl/microc_stack.sv
// microc_stack: single-cycle microcontroller datapath with a hardware
// return-address stack and zero/carry flags.
//
// Program memory is external: pc is driven out and instr comes back in the
// same cycle. An external control unit decodes opcode and drives the
// select/enable inputs.
//
// Optional build macro: MICROC_STACK_TRAP_EN. When defined, a stack
// overflow or underflow sends the PC to TRAP_VEC instead of the normal
// target / PC+1.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pc                  program counter / program memory address
//   instr               instruction word for pc (DW+8 bits)
//   opcode              instr[DW+7:DW+4], to the control unit
//   s_inc, s_inm        next-PC select, write-back data select
//   we3, wez            register write enable, flag write enable
//   op                  ALU operation
//   s_call, s_ret       call / return
//   z, c                registered zero and carry/borrow flags
//   stk_full/empty      stack occupancy (combinational from sp)
//   stk_err             sticky overflow/underflow, cleared only by reset
module microc_stack #(
    parameter int          DW       = 8,
    parameter int          PW       = 10,
    parameter int          SD       = 4,
    parameter int unsigned TRAP_VEC = 0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [PW-1:0] pc,
    input  logic [DW+7:0] instr,
    output logic [3:0]    opcode,
    input  logic          s_inc,
    input  logic          s_inm,
    input  logic          we3,
    input  logic          wez,
    input  logic [2:0]    op,
    input  logic          s_call,
    input  logic          s_ret,
    output logic          z,
    output logic          c,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          stk_err
);
    localparam int SPW = $clog2(SD + 1);   // sp counts 0..SD inclusive
    localparam int IW  = $clog2(SD);       // index into SD entries
`ifdef MICROC_STACK_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [PW-1:0] TRAP_PC = PW'(TRAP_VEC);

    logic [3:0]    rs1, rs2, rd;
    logic [DW-1:0] imm, a, b, alu_y, wd;
    logic [DW:0]   sum;
    logic          c_nx;
    logic [PW-1:0] target, pc_inc, pc_nx, top;
    logic [SPW-1:0] sp, top_idx;
    logic          push, pop, fault;

    logic [DW-1:0] rf  [16];
    logic [PW-1:0] stk [SD];

    assign opcode = instr[DW+7:DW+4];
    assign rs1    = instr[11:8];
    assign rs2    = instr[7:4];
    assign rd     = instr[3:0];
    assign imm    = instr[DW+3:4];
    assign target = instr[PW-1:0];

    // r0 is hard-wired to zero on the read side; its storage is never written.
    assign a = (rs1 == 4'd0) ? '0 : rf[rs1];
    assign b = (rs2 == 4'd0) ? '0 : rf[rs2];

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_y = a;
        c_nx  = 1'b0;
        case (op)
            3'b000: alu_y = a;
            3'b001: alu_y = ~a;
            3'b010: begin alu_y = sum[DW-1:0]; c_nx = sum[DW]; end
            3'b011: begin alu_y = a - b;       c_nx = (a < b);  end
            3'b100: alu_y = a & b;
            3'b101: alu_y = a | b;
            3'b110: alu_y = '0 - a;
            default: alu_y = '0 - b;
        endcase
    end

    assign wd = s_inm ? imm : alu_y;

    // Stack occupancy and top-of-stack (top is meaningless when empty).
    assign stk_full  = (sp == SPW'(SD));
    assign stk_empty = (sp == '0);
    assign top_idx   = sp - SPW'(1);
    assign top       = stk[top_idx[IW-1:0]];

    // PC+1 wraps naturally at PW bits; the pushed return address uses it too.
    assign pc_inc = pc + PW'(1);

    // Next-PC: return beats call, and either one overrides s_inc.
    always_comb begin
        pc_nx = s_inc ? pc_inc : target;
        push  = 1'b0;
        pop   = 1'b0;
        fault = 1'b0;
        if (s_ret) begin
            if (!stk_empty) begin
                pc_nx = top;
                pop   = 1'b1;
            end else begin
                fault = 1'b1;
                pc_nx = TRAP_EN ? TRAP_PC : pc_inc;
            end
        end else if (s_call) begin
            pc_nx = target;
            if (!stk_full) begin
                push = 1'b1;
            end else begin
                fault = 1'b1;
                if (TRAP_EN) pc_nx = TRAP_PC;
            end
        end
    end

    // Storage arrays: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (we3 && rd != 4'd0) rf[rd] <= wd;
        if (push)              stk[sp[IW-1:0]] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            pc <= pc_nx;
            if (wez) begin
                z <= (alu_y == '0);
                c <= c_nx;
            end
            if (push)      sp <= sp + SPW'(1);
            else if (pop)  sp <= sp - SPW'(1);
            if (fault)     stk_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_microc_stack.sv
// Directed bench for microc_stack (DW=8, PW=10, SD=4, TRAP_VEC=0x3F0).
// Stimulus pushes hand-derived expected post-edge state into a queue; a
// monitor pops and compares one entry per clock, #1 after the rising edge.
module tb_microc_stack;
`ifdef MICROC_STACK_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pc;
    logic [15:0] instr = '0;
    logic [3:0]  opcode;
    logic        s_inc = 0, s_inm = 0, we3 = 0, wez = 0, s_call = 0, s_ret = 0;
    logic [2:0]  op = '0;
    logic        z, c, stk_full, stk_empty, stk_err;

    microc_stack #(.DW(8), .PW(10), .SD(4), .TRAP_VEC(32'h3F0)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .opcode(opcode),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op),
        .s_call(s_call), .s_ret(s_ret), .z(z), .c(c),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] pc;
        logic [3:0] opc;
        logic       z, c, full, empty, err;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   vectors = 0;
    int   miscompares = 0;

    // Expected architectural state, maintained by hand in the stimulus.
    logic [9:0] epc;
    logic       ez, ec, eerr;
    int         esp;

    function automatic logic [9:0] tr(input logic [9:0] x);
        return TRAP_ON ? 10'h3F0 : x;
    endfunction

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            vectors++;
            if ({pc, opcode, z, c, stk_full, stk_empty, stk_err} !==
                {me.pc, me.opc, me.z, me.c, me.full, me.empty, me.err}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h opc=%h z=%b c=%b full=%b empty=%b err=%b, want pc=%h opc=%h z=%b c=%b full=%b empty=%b err=%b",
                         me.name, pc, opcode, z, c, stk_full, stk_empty, stk_err,
                         me.pc, me.opc, me.z, me.c, me.full, me.empty, me.err);
            end
        end
    end

    task automatic step(input string nm, input logic [3:0] opc,
                        input logic rst, i_inc, i_inm, i_we3, i_wez, i_call, i_ret,
                        input logic [2:0] i_op, input logic [11:0] lo);
        exp_t e;
        @(negedge clk);
        reset = rst; s_inc = i_inc; s_inm = i_inm; we3 = i_we3; wez = i_wez;
        s_call = i_call; s_ret = i_ret; op = i_op; instr = {opc, lo};
        e.name = nm; e.pc = epc; e.opc = opc; e.z = ez; e.c = ec;
        e.full = (esp == 4); e.empty = (esp == 0); e.err = eerr;
        q.push_back(e);
    endtask

    task automatic t_rst(input string nm);
        epc = '0; ez = 0; ec = 0; esp = 0; eerr = 0;
        step(nm, 4'h0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 12'h0);
    endtask

    task automatic t_inc(input string nm);
        epc = epc + 10'd1;
        step(nm, 4'h0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 12'h0);
    endtask

    task automatic t_ldi(input string nm, input logic [3:0] rd, input logic [7:0] imm);
        epc = epc + 10'd1;
        step(nm, 4'h1, 0, 1, 1, 1, 0, 0, 0, 3'd0, {imm, rd});
    endtask

    task automatic t_alu(input string nm, input logic [2:0] o,
                         input logic [3:0] rs1, rs2, rd, input logic w3, wz, xz, xc);
        epc = epc + 10'd1;
        if (wz) begin ez = xz; ec = xc; end
        step(nm, 4'h2, 0, 1, 0, w3, wz, 0, 0, o, {rs1, rs2, rd});
    endtask

    task automatic t_jmp(input string nm, input logic [9:0] t);
        epc = t;
        step(nm, 4'h3, 0, 0, 0, 0, 0, 0, 0, 3'd0, {2'b00, t});
    endtask

    // s_inc is held high on call/return to show it is ignored there.
    task automatic t_call(input string nm, input logic [9:0] t,
                          input logic [9:0] xpc, input int xsp, input logic xerr);
        epc = xpc; esp = xsp; eerr = xerr;
        step(nm, 4'h4, 0, 1, 0, 0, 0, 1, 0, 3'd0, {2'b00, t});
    endtask

    task automatic t_ret(input string nm, input logic [9:0] xpc, input int xsp, input logic xerr);
        epc = xpc; esp = xsp; eerr = xerr;
        step(nm, 4'h5, 0, 1, 0, 0, 0, 0, 1, 3'd0, 12'h155);
    endtask

    task automatic t_cr(input string nm, input logic [9:0] t,
                        input logic [9:0] xpc, input int xsp, input logic xerr);
        epc = xpc; esp = xsp; eerr = xerr;
        step(nm, 4'h6, 0, 1, 0, 0, 0, 1, 1, 3'd0, {2'b00, t});
    endtask

    initial begin
        t_rst("reset");
        t_inc("inc1"); t_inc("inc2"); t_inc("inc3");
        t_ldi("ldi_r1", 4'd1, 8'hF0);
        t_ldi("ldi_r2", 4'd2, 8'h20);                       // pc = 5
        t_call("call_100", 10'h100, 10'h100, 1, 0);
        t_ret("ret_6", 10'h006, 0, 0);
        t_alu("add_r1r2", 3'b010, 4'd1, 4'd2, 4'd3, 1, 1, 0, 1);  // 0x110 -> r3=0x10
        t_alu("sub_r2r2", 3'b011, 4'd2, 4'd2, 4'd0, 0, 1, 1, 0);
        t_alu("sub_r2r1", 3'b011, 4'd2, 4'd1, 4'd0, 0, 1, 0, 1);  // 0x30, borrow
        t_ldi("ldi_r4", 4'd4, 8'h10);
        t_alu("chk_r3", 3'b011, 4'd3, 4'd4, 4'd0, 0, 1, 1, 0);    // r3 == 0x10
        t_alu("not_r0", 3'b001, 4'd0, 4'd0, 4'd0, 0, 1, 0, 0);    // 0xFF
        t_alu("neg_r0", 3'b110, 4'd0, 4'd0, 4'd0, 0, 1, 1, 0);
        t_alu("and_r1r2", 3'b100, 4'd1, 4'd2, 4'd0, 0, 1, 0, 0);  // 0x20
        t_alu("and_r2r4", 3'b100, 4'd2, 4'd4, 4'd0, 0, 1, 1, 0);  // 0x00
        t_alu("add_wrap", 3'b010, 4'd1, 4'd4, 4'd0, 0, 1, 1, 1);  // 0x100 -> 0, carry
        t_alu("negb_r2", 3'b111, 4'd0, 4'd2, 4'd0, 0, 1, 0, 0);   // 0xE0
        t_alu("or_r0r0", 3'b101, 4'd0, 4'd0, 4'd0, 0, 1, 1, 0);
        t_alu("nowez", 3'b000, 4'd1, 4'd0, 4'd0, 0, 0, 0, 0);     // flags hold
        t_alu("pass_r1", 3'b000, 4'd1, 4'd0, 4'd0, 0, 1, 0, 0);
        t_ldi("ldi_r0", 4'd0, 8'hAA);
        t_alu("read_r0", 3'b000, 4'd0, 4'd0, 4'd0, 0, 1, 1, 0);   // r0 still 0

        t_jmp("jmp_080", 10'h080);
        t_call("call1", 10'h200, 10'h200, 1, 0);
        t_call("call2", 10'h210, 10'h210, 2, 0);
        t_call("call3", 10'h220, 10'h220, 3, 0);
        t_call("call4_full", 10'h230, 10'h230, 4, 0);
        t_call("call5_ovf", 10'h240, tr(10'h240), 4, 1);
        t_ret("ret4", 10'h221, 3, 1);
        t_ret("ret3", 10'h211, 2, 1);
        t_ret("ret2", 10'h201, 1, 1);
        t_ret("ret1", 10'h081, 0, 1);
        t_ret("ret_unf", tr(10'h082), 0, 1);

        t_jmp("jmp_090", 10'h090);
        t_call("call_300", 10'h300, 10'h300, 1, 1);
        t_cr("call_ret", 10'h111, 10'h091, 0, 1);

        t_call("callA", 10'h120, 10'h120, 1, 1);
        t_call("callB", 10'h130, 10'h130, 2, 1);
        t_rst("mid_reset");
        t_ret("ret_empty", tr(10'h001), 0, 1);

        t_jmp("jmp_3ff", 10'h3FF);
        t_call("call_wrap", 10'h050, 10'h050, 1, 1);
        t_ret("ret_wrap", 10'h000, 0, 1);
        t_jmp("jmp_3ff_b", 10'h3FF);
        t_inc("inc_wrap");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
